// File: rtl/row_converter_pkg.sv
// Shared types and constants for the 8x8 LED-matrix row converter.
// Build option: ROW_CONVERTER_ACTIVE_LOW_EN selects common-anode (inverted) drive.
package row_converter_pkg;

    localparam int GRID_SIZE = 8;
    localparam int COORD_W   = 3;

    typedef logic [COORD_W-1:0]   coord_t;
    typedef logic [GRID_SIZE-1:0] row_t;

`ifdef ROW_CONVERTER_ACTIVE_LOW_EN
    localparam row_t ROW_IDLE = 8'hFF;
`else
    localparam row_t ROW_IDLE = 8'h00;
`endif

    // Map a logical lit-pattern (1 = LED on) to the physical drive level.
    function automatic row_t drive_level(input row_t lit);
`ifdef ROW_CONVERTER_ACTIVE_LOW_EN
        return ~lit;
`else
        return lit;
`endif
    endfunction

endpackage

// File: rtl/onehot_dec3.sv
// Combinational 3-bit to 8-bit one-hot decoder.
module onehot_dec3
    import row_converter_pkg::*;
(
    input  logic [2:0] sel_i,
    output logic [7:0] onehot_o
);

    // Full decode so no input value can leave the output undriven.
    always_comb begin
        case (sel_i)
            3'd0:    onehot_o = 8'h01;
            3'd1:    onehot_o = 8'h02;
            3'd2:    onehot_o = 8'h04;
            3'd3:    onehot_o = 8'h08;
            3'd4:    onehot_o = 8'h10;
            3'd5:    onehot_o = 8'h20;
            3'd6:    onehot_o = 8'h40;
            3'd7:    onehot_o = 8'h80;
            default: onehot_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/row_converter.sv
// Converts one (x, y) cell coordinate into eight registered row patterns, one LED lit.
// Build option: ROW_CONVERTER_ACTIVE_LOW_EN inverts every output bit and the reset value.
module row_converter
    import row_converter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] coordinate_x,
    input  logic [2:0] coordinate_y,
    output logic [7:0] row1,
    output logic [7:0] row2,
    output logic [7:0] row3,
    output logic [7:0] row4,
    output logic [7:0] row5,
    output logic [7:0] row6,
    output logic [7:0] row7,
    output logic [7:0] row8
);

    row_t                  col_s;
    row_t                  sel_s;
    row_t [GRID_SIZE-1:0]  rows_d;
    row_t [GRID_SIZE-1:0]  rows_q;

    onehot_dec3 u_col_dec (
        .sel_i    (coordinate_x),
        .onehot_o (col_s)
    );

    onehot_dec3 u_row_dec (
        .sel_i    (coordinate_y),
        .onehot_o (sel_s)
    );

    // Gate the column pattern onto the selected row only.
    always_comb begin
        rows_d = '0;
        for (int k = 0; k < GRID_SIZE; k++) begin
            rows_d[k] = drive_level(col_s & {GRID_SIZE{sel_s[k]}});
        end
    end

    // Output registers; reset forces every row to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q <= {GRID_SIZE{ROW_IDLE}};
        end else begin
            rows_q <= rows_d;
        end
    end

    assign row1 = rows_q[0];
    assign row2 = rows_q[1];
    assign row3 = rows_q[2];
    assign row4 = rows_q[3];
    assign row5 = rows_q[4];
    assign row6 = rows_q[5];
    assign row7 = rows_q[6];
    assign row8 = rows_q[7];

endmodule

// File: tb/tb_row_converter.sv
// Self-checking bench for row_converter: behavioural model, per-cycle compare, literal pins.
module tb_row_converter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] coordinate_x;
    logic [2:0] coordinate_y;
    logic [7:0] row1, row2, row3, row4, row5, row6, row7, row8;
    logic [7:0] rows_a [8];

    int passed = 0;
    int total  = 0;

`ifdef ROW_CONVERTER_ACTIVE_LOW_EN
    localparam logic [7:0] IDLE_V = 8'hFF;
`else
    localparam logic [7:0] IDLE_V = 8'h00;
`endif

    function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef ROW_CONVERTER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    row_converter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coordinate_x (coordinate_x),
        .coordinate_y (coordinate_y),
        .row1         (row1),
        .row2         (row2),
        .row3         (row3),
        .row4         (row4),
        .row5         (row5),
        .row6         (row6),
        .row7         (row7),
        .row8         (row8)
    );

    always #5 clk = ~clk;

    assign rows_a[0] = row1;
    assign rows_a[1] = row2;
    assign rows_a[2] = row3;
    assign rows_a[3] = row4;
    assign rows_a[4] = row5;
    assign rows_a[5] = row6;
    assign rows_a[6] = row7;
    assign rows_a[7] = row8;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s row%0d: got %h expected %h at %0t", name, idx + 1, act, exp, $time);
        end
    endtask

    // Model: the coordinate sampled at the last edge since reset, or nothing yet.
    logic       m_valid;
    logic [2:0] m_x, m_y;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_x     <= 3'd0;
            m_y     <= 3'd0;
        end else begin
            m_valid <= 1'b1;
            m_x     <= coordinate_x;
            m_y     <= coordinate_y;
        end
    end

    // Per-cycle compare of all rows plus the single-lit-LED invariant.
    always @(negedge clk) begin
        int lit;
        lit = 0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] e;
            e = (m_valid && (int'(m_y) == k)) ? pol(8'h01 << m_x) : IDLE_V;
            check("model", k, rows_a[k], e);
            lit += $countones(rows_a[k] ^ IDLE_V);
        end
        if (m_valid) begin
            total++;
            if (lit == 1) passed++;
            else $display("FAIL popcount: got %0d lit LEDs expected 1 at %0t", lit, $time);
        end
    end

    task automatic apply(input logic [2:0] x, input logic [2:0] y);
        @(negedge clk);
        coordinate_x = x;
        coordinate_y = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        coordinate_x = 3'd5;
        coordinate_y = 3'd3;
        #2;
        for (int k = 0; k < 8; k++) check("reset_noclk", k, rows_a[k], IDLE_V);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) check("reset_held", k, rows_a[k], IDLE_V);

        @(negedge clk);
        rst_n = 1'b1;
        apply(3'd0, 3'd0);
        check("first_00", 0, row1, pol(8'h01));
        for (int k = 1; k < 8; k++) check("first_00_other", k, rows_a[k], IDLE_V);

        // Full sweep; every cell is checked at its own row.
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                logic [7:0] one;
                one = 8'h01;
                apply(3'(x), 3'(y));
                check("sweep", y, rows_a[y], pol(one << x));
            end
        end

        apply(3'd5, 3'd3);
        check("y3x5", 3, row4, pol(8'h20));
        apply(3'd7, 3'd0);
        check("corner_x7y0", 0, row1, pol(8'h80));
        apply(3'd0, 3'd7);
        check("corner_x0y7", 7, row8, pol(8'h01));
`ifdef ROW_CONVERTER_ACTIVE_LOW_EN
        apply(3'd3, 3'd2);
        check("al_x3y2", 2, row3, 8'hF7);
        check("al_x3y2_other", 0, row1, 8'hFF);
`endif

        // Latency: a change between edges is invisible until the next edge.
        apply(3'd2, 3'd1);
        check("lat_before", 1, row2, pol(8'h04));
        @(negedge clk);
        coordinate_x = 3'd6;
        #1;
        check("lat_hold", 1, row2, pol(8'h04));
        @(posedge clk);
        #1;
        check("lat_after", 1, row2, pol(8'h40));

        // Asynchronous reset mid-run.
        apply(3'd7, 3'd7);
        check("pre_rst_x7y7", 7, row8, pol(8'h80));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 7, row8, IDLE_V);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_noedge", 7, row8, IDLE_V);
        @(posedge clk);
        #1;
        check("post_rst_edge", 7, row8, pol(8'h80));

        // Randomised run; the per-cycle compare does the checking.
        repeat (400) begin
            @(negedge clk);
            coordinate_x = 3'($urandom_range(0, 7));
            coordinate_y = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
